// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing, colour type, sync polarities and test-bar helper
package vga_pkg;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_H_ACT  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;
   localparam int VGA_V_ACT  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int COLOUR_W   = 4;
   localparam bit SYNC_ACT_LOW  = 1'b0;
   localparam bit SYNC_ACT_HIGH = 1'b1;
   typedef struct packed {
      logic [COLOUR_W-1:0] b, g, r;
   } colour_t;
   // bar k lights channel r/g/b when bit 0/1/2 of k is set
   function automatic colour_t bar_colour(input logic [2:0] k);
      return {{COLOUR_W{k[2]}}, {COLOUR_W{k[1]}}, {COLOUR_W{k[0]}}};
   endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit wide, D-deep register shift chain with async active-low clear
// i_clk clock, i_rst_n async clear, i_d input word, o_q input delayed by D clocks
module vga_delay_line #(
   parameter int W = 1,
   parameter int D = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_sr [D];
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         for (int i = 0; i < D; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
      end
   assign o_q = r_sr[D-1];
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: parametrised VGA timing generator and pixel output pipeline
// vga_clk pixel clock; clrn async active-low reset; d_in {b,g,r} pixel data from RAM
// row_addr/col_addr active-area indices; rdn RAM read strobe (active-low, window only)
// r/g/b colour, hs/vs sync, de data enable, frame_start/line_start first-pixel strobes
// VGA_TESTPAT_EN adds test_mode: eight vertical colour bars replace d_in in the window
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP   = VGA_H_BP,
   parameter int H_ACT  = VGA_H_ACT,
   parameter int H_FP   = VGA_H_FP,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP   = VGA_V_BP,
   parameter int V_ACT  = VGA_V_ACT,
   parameter int V_FP   = VGA_V_FP,
   parameter bit HS_POL = SYNC_ACT_LOW,
   parameter bit VS_POL = SYNC_ACT_LOW,
   parameter int CW     = 4,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1,
   parameter int WIN_W  = 512,
   parameter int WIN_H  = 480,
   parameter logic [3*CW-1:0] BORDER = '0
) (
   input  logic              vga_clk,
   input  logic              clrn,
`ifdef VGA_TESTPAT_EN
   input  logic              test_mode,
`endif
   input  logic [3*CW-1:0]   d_in,
   output logic [ADDR_W-1:0] row_addr,
   output logic [ADDR_W-1:0] col_addr,
   output logic              rdn,
   output logic [CW-1:0]     r,
   output logic [CW-1:0]     g,
   output logic [CW-1:0]     b,
   output logic              hs,
   output logic              vs,
   output logic              de,
   output logic              frame_start,
   output logic              line_start
);
   localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int H_ST  = H_SYNC + H_BP;
   localparam int V_ST  = V_SYNC + V_BP;
   if (WIN_W > H_ACT || WIN_H > V_ACT || RD_LAT < 1 || RD_LAT > 4) begin : g_bad_cfg
      $error("vga_timing_ctrl: window exceeds active area or RD_LAT outside 1..4");
   end
   logic [HW-1:0] r_h_cnt, w_hc;
   logic [VW-1:0] r_v_cnt, w_vc;
   logic w_h_end, w_act, w_win, w_rd, w_hs_act, w_vs_act, w_fs, w_ls;
   logic w_q_act, w_q_win, w_q_hs, w_q_vs, w_q_fs, w_q_ls;
   logic [3*CW-1:0] w_din;
   assign w_h_end = r_h_cnt == HW'(H_TOT - 1);
   always_ff @(posedge vga_clk or negedge clrn)
      if (!clrn) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         r_h_cnt <= w_h_end ? '0 : r_h_cnt + HW'(1);
         if (w_h_end) r_v_cnt <= (r_v_cnt == VW'(V_TOT - 1)) ? '0 : r_v_cnt + VW'(1);
      end
   // offsets wrap below the active start, so the range test needs the lower bound too
   assign w_hc     = r_h_cnt - HW'(H_ST);
   assign w_vc     = r_v_cnt - VW'(V_ST);
   assign w_act    = r_h_cnt >= HW'(H_ST) && w_hc < HW'(H_ACT) && r_v_cnt >= VW'(V_ST) && w_vc < VW'(V_ACT);
   assign w_win    = w_act && w_hc < HW'(WIN_W) && w_vc < VW'(WIN_H);
   assign w_hs_act = r_h_cnt < HW'(H_SYNC);
   assign w_vs_act = r_v_cnt < VW'(V_SYNC);
   assign w_ls     = w_act && w_hc == '0;
   assign w_fs     = w_ls && w_vc == '0;
`ifdef VGA_TESTPAT_EN
   localparam int CTL_W = 10;
   localparam int BAR_W = WIN_W >= 8 ? WIN_W / 8 : 1;
   logic [2:0] w_bar, w_q_bar;
   logic w_q_tm;
   colour_t w_bar_c;
   logic [CTL_W-1:0] w_ctl, w_q;
   assign w_bar = 3'(w_hc / HW'(BAR_W));
   assign w_rd  = w_win && !test_mode;
   assign w_ctl = {test_mode, w_bar, w_act, w_win, w_hs_act, w_vs_act, w_fs, w_ls};
   assign {w_q_tm, w_q_bar, w_q_act, w_q_win, w_q_hs, w_q_vs, w_q_fs, w_q_ls} = w_q;
   assign w_bar_c = bar_colour(w_q_bar);
   assign w_din = w_q_tm ? {{CW{w_bar_c.b[0]}}, {CW{w_bar_c.g[0]}}, {CW{w_bar_c.r[0]}}} : d_in;
`else
   localparam int CTL_W = 6;
   logic [CTL_W-1:0] w_ctl, w_q;
   assign w_rd  = w_win;
   assign w_ctl = {w_act, w_win, w_hs_act, w_vs_act, w_fs, w_ls};
   assign {w_q_act, w_q_win, w_q_hs, w_q_vs, w_q_fs, w_q_ls} = w_q;
   assign w_din = d_in;
`endif
   // stage 0: address and read strobe toward the pixel RAM
   always_ff @(posedge vga_clk or negedge clrn)
      if (!clrn) begin
         row_addr <= '0;
         col_addr <= '0;
         rdn      <= 1'b1;
      end else begin
         row_addr <= ADDR_W'(w_vc);
         col_addr <= ADDR_W'(w_hc);
         rdn      <= ~w_rd;
      end
   // control bits ride alongside the RAM read so sync stays aligned with pixel data
   vga_delay_line #(.W(CTL_W), .D(RD_LAT)) u_dly (
      .i_clk   (vga_clk),
      .i_rst_n (clrn),
      .i_d     (w_ctl),
      .o_q     (w_q)
   );
   always_ff @(posedge vga_clk or negedge clrn)
      if (!clrn) begin
         {b, g, r}   <= '0;
         de          <= 1'b0;
         hs          <= ~HS_POL;
         vs          <= ~VS_POL;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         {b, g, r}   <= w_q_win ? w_din : w_q_act ? BORDER : '0;
         de          <= w_q_act;
         hs          <= w_q_hs ? HS_POL : ~HS_POL;
         vs          <= w_q_vs ? VS_POL : ~VS_POL;
         frame_start <= w_q_fs;
         line_start  <= w_q_ls;
      end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks of two small-timing controllers (RD_LAT 1 low-sync, RD_LAT 3 high-sync)
module tb_vga_timing_ctrl;
   localparam int HT = 29, VT = 11, HST = 7, VST = 4, HA = 20, VA = 6, FR = HT * VT;
   logic vga_clk = 1'b0, clrn = 1'b0, tm = 1'b0;
   logic [11:0] d_a, d_b, p1 = '0, p2 = '0;
   logic [5:0] ra, ca, rb, cb;
   logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
   logic rdn_a, hs_a, vs_a, de_a, fs_a, ls_a;
   logic rdn_b, hs_b, vs_b, de_b, fs_b, ls_b;
   int errors = 0, checks = 0, n = 0;
   always #5 vga_clk = ~vga_clk;
   // A: RAM returns data combinationally (RD_LAT=1); B: two extra RAM stages (RD_LAT=3)
   assign d_a = {4'hA, ra[3:0], ca[3:0]};
   always @(posedge vga_clk) begin
      p1 <= {4'h5, rb[3:0], cb[3:0]};
      p2 <= p1;
   end
   assign d_b = p2;
   vga_timing_ctrl #(.H_SYNC(4), .H_BP(3), .H_ACT(20), .H_FP(2), .V_SYNC(2), .V_BP(2), .V_ACT(6), .V_FP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .ADDR_W(6), .RD_LAT(1), .WIN_W(16), .WIN_H(4), .BORDER(12'h123)) u_a (
      .vga_clk(vga_clk), .clrn(clrn),
`ifdef VGA_TESTPAT_EN
      .test_mode(tm),
`endif
      .d_in(d_a), .row_addr(ra), .col_addr(ca), .rdn(rdn_a), .r(r_a), .g(g_a), .b(b_a),
      .hs(hs_a), .vs(vs_a), .de(de_a), .frame_start(fs_a), .line_start(ls_a));
   vga_timing_ctrl #(.H_SYNC(4), .H_BP(3), .H_ACT(20), .H_FP(2), .V_SYNC(2), .V_BP(2), .V_ACT(6), .V_FP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .ADDR_W(6), .RD_LAT(3), .WIN_W(20), .WIN_H(6), .BORDER(12'h000)) u_b (
      .vga_clk(vga_clk), .clrn(clrn),
`ifdef VGA_TESTPAT_EN
      .test_mode(1'b0),
`endif
      .d_in(d_b), .row_addr(rb), .col_addr(cb), .rdn(rdn_b), .r(r_b), .g(g_b), .b(b_b),
      .hs(hs_b), .vs(vs_b), .de(de_b), .frame_start(fs_b), .line_start(ls_b));
   function automatic int hc_of(int c); return c % HT; endfunction
   function automatic int vc_of(int c); return (c / HT) % VT; endfunction
   function automatic bit act_of(int c);
      return c >= 0 && hc_of(c) >= HST && hc_of(c) < HST + HA && vc_of(c) >= VST && vc_of(c) < VST + VA;
   endfunction
   function automatic bit win_of(int c, int ww, int wh);
      return act_of(c) && hc_of(c) - HST < ww && vc_of(c) - VST < wh;
   endfunction
   task automatic tick();
      @(posedge vga_clk);
      #1;
      n++;
   endtask
   task automatic restart();
      clrn = 1'b0;
      repeat (2) @(negedge vga_clk);
      clrn = 1'b1;
      n = 0;
   endtask
   task automatic test_reset();
      #12;
      checks += 6;
      if ({rdn_a, hs_a, vs_a, de_a, fs_a, ls_a} !== 6'b111000) begin errors++; $display("FAIL reset_ctl_a got=%b exp=111000", {rdn_a, hs_a, vs_a, de_a, fs_a, ls_a}); end
      if ({rdn_b, hs_b, vs_b, de_b, fs_b, ls_b} !== 6'b100000) begin errors++; $display("FAIL reset_ctl_b got=%b exp=100000", {rdn_b, hs_b, vs_b, de_b, fs_b, ls_b}); end
      if ({b_a, g_a, r_a} !== 12'h0) begin errors++; $display("FAIL reset_rgb_a got=%h exp=000", {b_a, g_a, r_a}); end
      if ({b_b, g_b, r_b} !== 12'h0) begin errors++; $display("FAIL reset_rgb_b got=%h exp=000", {b_b, g_b, r_b}); end
      if ({ra, ca} !== 12'h0) begin errors++; $display("FAIL reset_addr_a got=%h exp=000", {ra, ca}); end
      if ({rb, cb} !== 12'h0) begin errors++; $display("FAIL reset_addr_b got=%h exp=000", {rb, cb}); end
   endtask
   task automatic test_sync();
      int ha = 0, va = 0, hb = 0, vb = 0;
      bit eh, ev;
      restart();
      for (int i = 0; i < 2 * FR + 4; i++) begin
         tick();
         eh = n - 2 >= 0 && hc_of(n - 2) < 4;
         ev = n - 2 >= 0 && vc_of(n - 2) < 2;
         checks += 4;
         if (hs_a !== ~eh) begin errors++; $display("FAIL hs_a n=%0d got=%b exp=%b", n, hs_a, ~eh); end
         if (vs_a !== ~ev) begin errors++; $display("FAIL vs_a n=%0d got=%b exp=%b", n, vs_a, ~ev); end
         eh = n - 4 >= 0 && hc_of(n - 4) < 4;
         ev = n - 4 >= 0 && vc_of(n - 4) < 2;
         if (hs_b !== eh) begin errors++; $display("FAIL hs_b n=%0d got=%b exp=%b", n, hs_b, eh); end
         if (vs_b !== ev) begin errors++; $display("FAIL vs_b n=%0d got=%b exp=%b", n, vs_b, ev); end
         if (n >= 2 && n < 2 + FR) begin ha += int'(!hs_a); va += int'(!vs_a); end
         if (n >= 4 && n < 4 + FR) begin hb += int'(hs_b); vb += int'(vs_b); end
      end
      checks += 4;
      if (ha != 44) begin errors++; $display("FAIL hs_a_active_per_frame got=%0d exp=44", ha); end
      if (va != 58) begin errors++; $display("FAIL vs_a_active_per_frame got=%0d exp=58", va); end
      if (hb != 44) begin errors++; $display("FAIL hs_b_active_per_frame got=%0d exp=44", hb); end
      if (vb != 58) begin errors++; $display("FAIL vs_b_active_per_frame got=%0d exp=58", vb); end
   endtask
   task automatic test_colour();
      int da = 0, db = 0, bord = 0, c;
      logic [11:0] ea, eb;
      restart();
      for (int i = 0; i < FR + 4; i++) begin
         tick();
         c = n - 2;
         ea = win_of(c, 16, 4) ? {4'hA, 4'(vc_of(c) - VST), 4'(hc_of(c) - HST)} : act_of(c) ? 12'h123 : 12'h000;
         checks += 4;
         if ({b_a, g_a, r_a} !== ea) begin errors++; $display("FAIL rgb_a n=%0d got=%h exp=%h", n, {b_a, g_a, r_a}, ea); end
         if (de_a !== act_of(c)) begin errors++; $display("FAIL de_a n=%0d got=%b exp=%b", n, de_a, act_of(c)); end
         c = n - 4;
         eb = win_of(c, 20, 6) ? {4'h5, 4'(vc_of(c) - VST), 4'(hc_of(c) - HST)} : 12'h000;
         if ({b_b, g_b, r_b} !== eb) begin errors++; $display("FAIL rgb_b n=%0d got=%h exp=%h", n, {b_b, g_b, r_b}, eb); end
         if (de_b !== act_of(c)) begin errors++; $display("FAIL de_b n=%0d got=%b exp=%b", n, de_b, act_of(c)); end
         if (n >= 2 && n < 2 + FR) begin da += int'(de_a); bord += int'(de_a && {b_a, g_a, r_a} == 12'h123); end
         if (n >= 4 && n < 4 + FR) db += int'(de_b);
      end
      checks += 3;
      if (da != 120) begin errors++; $display("FAIL de_a_per_frame got=%0d exp=120", da); end
      if (db != 120) begin errors++; $display("FAIL de_b_per_frame got=%0d exp=120", db); end
      if (bord != 56) begin errors++; $display("FAIL border_a_per_frame got=%0d exp=56", bord); end
   endtask
   task automatic test_rdn_addr();
      int la = 0, lb = 0, c;
      restart();
      for (int i = 0; i < FR + 2; i++) begin
         tick();
         c = n - 1;
         checks += 2;
         if (rdn_a !== ~win_of(c, 16, 4)) begin errors++; $display("FAIL rdn_a n=%0d got=%b exp=%b", n, rdn_a, ~win_of(c, 16, 4)); end
         if (rdn_b !== ~win_of(c, 20, 6)) begin errors++; $display("FAIL rdn_b n=%0d got=%b exp=%b", n, rdn_b, ~win_of(c, 20, 6)); end
         if (act_of(c)) begin
            checks += 2;
            if ({ra, ca} !== {6'(vc_of(c) - VST), 6'(hc_of(c) - HST)}) begin errors++; $display("FAIL addr_a n=%0d got=%h exp=%h", n, {ra, ca}, {6'(vc_of(c) - VST), 6'(hc_of(c) - HST)}); end
            if ({rb, cb} !== {6'(vc_of(c) - VST), 6'(hc_of(c) - HST)}) begin errors++; $display("FAIL addr_b n=%0d got=%h exp=%h", n, {rb, cb}, {6'(vc_of(c) - VST), 6'(hc_of(c) - HST)}); end
         end
         if (n < 1 + FR) begin la += int'(!rdn_a); lb += int'(!rdn_b); end
      end
      checks += 2;
      if (la != 64) begin errors++; $display("FAIL rdn_a_low_per_frame got=%0d exp=64", la); end
      if (lb != 120) begin errors++; $display("FAIL rdn_b_low_per_frame got=%0d exp=120", lb); end
   endtask
   task automatic test_strobes();
      int fa = 0, la = 0, fb = 0, lb = 0, c;
      bit ef, el;
      restart();
      for (int i = 0; i < FR + 4; i++) begin
         tick();
         c = n - 2;
         el = act_of(c) && hc_of(c) == HST;
         ef = el && vc_of(c) == VST;
         checks += 4;
         if (fs_a !== ef) begin errors++; $display("FAIL fs_a n=%0d got=%b exp=%b", n, fs_a, ef); end
         if (ls_a !== el) begin errors++; $display("FAIL ls_a n=%0d got=%b exp=%b", n, ls_a, el); end
         c = n - 4;
         el = act_of(c) && hc_of(c) == HST;
         ef = el && vc_of(c) == VST;
         if (fs_b !== ef) begin errors++; $display("FAIL fs_b n=%0d got=%b exp=%b", n, fs_b, ef); end
         if (ls_b !== el) begin errors++; $display("FAIL ls_b n=%0d got=%b exp=%b", n, ls_b, el); end
         if (n >= 2 && n < 2 + FR) begin fa += int'(fs_a); la += int'(ls_a); end
         if (n >= 4 && n < 4 + FR) begin fb += int'(fs_b); lb += int'(ls_b); end
      end
      checks += 4;
      if (fa != 1) begin errors++; $display("FAIL fs_a_per_frame got=%0d exp=1", fa); end
      if (la != 6) begin errors++; $display("FAIL ls_a_per_frame got=%0d exp=6", la); end
      if (fb != 1) begin errors++; $display("FAIL fs_b_per_frame got=%0d exp=1", fb); end
      if (lb != 6) begin errors++; $display("FAIL ls_b_per_frame got=%0d exp=6", lb); end
   endtask
   task automatic test_mid_reset();
      int fa = -1, fb = -1;
      restart();
      while (n < 5 * HT + 10) tick();
      checks += 2;
      if (de_a !== 1'b1) begin errors++; $display("FAIL pre_reset_de_a got=%b exp=1", de_a); end
      if ({b_a, g_a, r_a} !== 12'hA11) begin errors++; $display("FAIL pre_reset_rgb_a got=%h exp=a11", {b_a, g_a, r_a}); end
      #2 clrn = 1'b0;
      #1;
      checks += 4;
      if ({rdn_a, hs_a, vs_a, de_a, fs_a, ls_a} !== 6'b111000) begin errors++; $display("FAIL midrst_ctl_a got=%b exp=111000", {rdn_a, hs_a, vs_a, de_a, fs_a, ls_a}); end
      if ({rdn_b, hs_b, vs_b, de_b, fs_b, ls_b} !== 6'b100000) begin errors++; $display("FAIL midrst_ctl_b got=%b exp=100000", {rdn_b, hs_b, vs_b, de_b, fs_b, ls_b}); end
      if ({b_a, g_a, r_a, b_b, g_b, r_b} !== 24'h0) begin errors++; $display("FAIL midrst_rgb got=%h exp=000000", {b_a, g_a, r_a, b_b, g_b, r_b}); end
      if ({ra, ca, rb, cb} !== 24'h0) begin errors++; $display("FAIL midrst_addr got=%h exp=000000", {ra, ca, rb, cb}); end
      restart();
      for (int i = 0; i < 400 && (fa < 0 || fb < 0); i++) begin
         tick();
         if (fs_a && fa < 0) fa = n;
         if (fs_b && fb < 0) fb = n;
      end
      checks += 2;
      if (fa != 125) begin errors++; $display("FAIL first_fs_a got=%0d exp=125", fa); end
      if (fb != 127) begin errors++; $display("FAIL first_fs_b got=%0d exp=127", fb); end
   endtask
`ifdef VGA_TESTPAT_EN
   task automatic test_testpat();
      int c;
      logic [2:0] k;
      logic [11:0] e;
      tm = 1'b1;
      restart();
      for (int i = 0; i < FR + 4; i++) begin
         tick();
         c = n - 2;
         k = 3'((hc_of(c) - HST) / 2);
         e = win_of(c, 16, 4) ? {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}} : act_of(c) ? 12'h123 : 12'h000;
         checks += 2;
         if ({b_a, g_a, r_a} !== e) begin errors++; $display("FAIL testpat_rgb n=%0d got=%h exp=%h", n, {b_a, g_a, r_a}, e); end
         if (rdn_a !== 1'b1) begin errors++; $display("FAIL testpat_rdn n=%0d got=%b exp=1", n, rdn_a); end
      end
      tm = 1'b0;
   endtask
`endif
   initial begin
      test_reset();
      test_sync();
      test_colour();
      test_rdn_addr();
      test_strobes();
      test_mid_reset();
`ifdef VGA_TESTPAT_EN
      test_testpat();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
